// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the logic-unit arbiter: opcode encodings and output-register FSM states.
package logic_unit_arbiter_pkg;

    localparam logic [1:0] LOP_AND   = 2'b00;
    localparam logic [1:0] LOP_OR    = 2'b01;
    localparam logic [1:0] LOP_XOR   = 2'b10;
    localparam logic [1:0] LOP_ANDCM = 2'b11;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/logic_unit_arbiter_op_unit.sv
// Purely combinational logic unit: y = op(a, b) for AND, OR, XOR and ANDCM (a & ~b).
module logic_op_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   op,
    input  logic [0:W-1] a,
    input  logic [0:W-1] b,
    output logic [0:W-1] y
);

    always_comb begin
        y = '0;
        case (op)
            LOP_AND:   y = a & b;
            LOP_OR:    y = a | b;
            LOP_XOR:   y = a ^ b;
            LOP_ANDCM: y = a & ~b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters, with a one-entry tagged result register.
// Optional registered zero flag on res_zero when LOGIC_ARB_ZFLAG_EN is defined.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [0:W-1] a0,
    input  logic [0:W-1] b0,
    input  logic [0:W-1] a1,
    input  logic [0:W-1] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         res_valid,
    output logic         res_tag,
    output logic [0:W-1] res_y,
`ifdef LOGIC_ARB_ZFLAG_EN
    output logic         res_zero,
`endif
    input  logic         res_ready
);

    logic [0:0]   r_state;
    logic         r_last;
    logic         r_tag;
    logic [0:W-1] r_y;

    logic         w_can_grant;
    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_any_gnt;
    logic [1:0]   w_op;
    logic [0:W-1] w_a;
    logic [0:W-1] w_b;
    logic [0:W-1] w_y;

    // A full register may only accept a new result in the cycle it is drained.
    assign w_can_grant = rst_n && ((r_state == ST_EMPTY) || res_ready);
    assign w_gnt0      = w_can_grant && req0 && (!req1 || r_last);
    assign w_gnt1      = w_can_grant && req1 && (!req0 || !r_last);
    assign w_any_gnt   = w_gnt0 || w_gnt1;

    assign w_op = w_gnt1 ? op1 : op0;
    assign w_a  = w_gnt1 ? a1  : a0;
    assign w_b  = w_gnt1 ? b1  : b0;

    logic_op_unit #(.W(W)) u_op (
        .op (w_op),
        .a  (w_a),
        .b  (w_b),
        .y  (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_last  <= 1'b1;
            r_tag   <= 1'b0;
            r_y     <= '0;
        end else if (w_any_gnt) begin
            r_state <= ST_FULL;
            r_last  <= w_gnt1;
            r_tag   <= w_gnt1;
            r_y     <= w_y;
        end else if ((r_state == ST_FULL) && res_ready) begin
            r_state <= ST_EMPTY;
        end
    end

`ifdef LOGIC_ARB_ZFLAG_EN
    logic r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
        end else if (w_any_gnt) begin
            r_zero <= (w_y == '0);
        end
    end

    assign res_zero = r_zero;
`endif

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign res_valid = (r_state == ST_FULL);
    assign res_tag   = r_tag;
    assign res_y     = r_y;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  op0 = 2'b00, op1 = 2'b00;
    logic [0:31] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, res_valid, res_tag, res_ready = 1'b1;
    logic [0:31] res_y;
`ifdef LOGIC_ARB_ZFLAG_EN
    logic        res_zero;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic        m_valid, m_tag, m_last, m_zero;
    logic [31:0] m_y;
    logic        last_g0, last_g1;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res_valid (res_valid),
        .res_tag   (res_tag),
        .res_y     (res_y),
`ifdef LOGIC_ARB_ZFLAG_EN
        .res_zero  (res_zero),
`endif
        .res_ready (res_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_tag = 1'b0; m_last = 1'b1; m_zero = 1'b0; m_y = '0;
        last_g0 = 1'b0; last_g1 = 1'b0;
    endtask

    // One clock: called just after a falling edge with inputs already applied.
    task automatic step();
        logic can, eg0, eg1;
        #1;
        can = !m_valid || res_ready;
        eg0 = can && req0 && (!req1 || m_last == 1'b1);
        eg1 = can && req1 && (!req0 || m_last == 1'b0);
        check("gnt0", {31'b0, gnt0}, {31'b0, eg0});
        check("gnt1", {31'b0, gnt1}, {31'b0, eg1});
        check("gnt_onehot", {31'b0, gnt0 & gnt1}, 32'd0);
        @(posedge clk);
        if (eg0 || eg1) begin
            m_y     = eg1 ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
            m_tag   = eg1;
            m_last  = eg1;
            m_valid = 1'b1;
            m_zero  = (m_y == 32'd0);
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        last_g0 = eg0;
        last_g1 = eg1;
        #1;
        check("res_valid", {31'b0, res_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("res_tag", {31'b0, res_tag}, {31'b0, m_tag});
            check("res_y", res_y, m_y);
`ifdef LOGIC_ARB_ZFLAG_EN
            check("res_zero", {31'b0, res_zero}, {31'b0, m_zero});
`endif
        end
        $display("cyc t=%0t req=%b%b gnt=%b%b ready=%b valid=%b tag=%b y=%h",
                 $time, req1, req0, gnt1, gnt0, res_ready, res_valid, res_tag, res_y);
        @(negedge clk);
    endtask

    logic [31:0] held_y;
    logic        held_tag, prev_g1;
    logic [31:0] exp_tbl [4];

    initial begin
        model_reset();
        exp_tbl[0] = 32'hF000F000;
        exp_tbl[1] = 32'hFFF0FFF0;
        exp_tbl[2] = 32'h0FF00FF0;
        exp_tbl[3] = 32'h00F000F0;

        // reset values
        req0 = 1'b1; req1 = 1'b1;
        #2;
        check("rst_gnt0", {31'b0, gnt0}, 32'd0);
        check("rst_gnt1", {31'b0, gnt1}, 32'd0);
        check("rst_valid", {31'b0, res_valid}, 32'd0);
        check("rst_tag", {31'b0, res_tag}, 32'd0);
        check("rst_y", res_y, 32'd0);
`ifdef LOGIC_ARB_ZFLAG_EN
        check("rst_zero", {31'b0, res_zero}, 32'd0);
`endif
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single OR request on port 0
        req0 = 1'b1; op0 = 2'b01; a0 = 32'h00F010FF; b0 = 32'h00FFF000;
        step();
        check("t1_gnt0", {31'b0, last_g0}, 32'd1);
        check("t1_y", res_y, 32'h00FFF0FF);
        check("t1_tag", {31'b0, res_tag}, 32'd0);
        req0 = 1'b0;
        step();

        // continuous contention: grants alternate, results back-to-back
        req0 = 1'b1; req1 = 1'b1; op1 = 2'b10; a1 = 32'h0000FFFF; b1 = 32'h00FF00FF;
        step();
        prev_g1 = last_g1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("alt", {31'b0, last_g1}, {31'b0, ~prev_g1});
            check("b2b_valid", {31'b0, res_valid}, 32'd1);
            prev_g1 = last_g1;
        end

        // stall for 3 cycles: outputs hold, no grants
        held_y = res_y; held_tag = res_tag;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_y", res_y, held_y);
            check("stall_tag", {31'b0, res_tag}, {31'b0, held_tag});
        end
        res_ready = 1'b1;
        step();
        check("rr_after_stall", {31'b0, last_g1}, {31'b0, ~held_tag});
        req0 = 1'b0; req1 = 1'b0;
        step();

        // every opcode on port 1
        for (int k = 0; k < 4; k++) begin
            req1 = 1'b1; op1 = k[1:0]; a1 = 32'hF0F0F0F0; b1 = 32'hFF00FF00;
            step();
            check("op_tbl", res_y, exp_tbl[k]);
        end
        req1 = 1'b0;
        step();

`ifdef LOGIC_ARB_ZFLAG_EN
        req0 = 1'b1; op0 = 2'b10; a0 = 32'h12345678; b0 = 32'h12345678;
        step();
        check("z_set_y", res_y, 32'd0);
        check("z_set", {31'b0, res_zero}, 32'd1);
        op0 = 2'b01; a0 = 32'h1; b0 = 32'h0;
        step();
        check("z_clr", {31'b0, res_zero}, 32'd0);
        req0 = 1'b0;
        step();
`endif

        // asynchronous reset while FULL and stalled
        req1 = 1'b1; op1 = 2'b00; a1 = 32'hFFFFFFFF; b1 = 32'h0F0F0F0F;
        step();
        req0 = 1'b1; res_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, res_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; res_ready = 1'b1;
        step();
        check("post_rst_winner0", {31'b0, last_g0}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        step();

        // randomized traffic; operands held while a request is pending
        for (int n = 0; n < 400; n++) begin
            if (!req0 || last_g0 || ($urandom_range(0, 15) == 0)) begin
                req0 = ($urandom_range(0, 3) != 0);
                op0  = 2'($urandom_range(0, 3));
                a0   = $urandom;
                b0   = ($urandom_range(0, 7) == 0) ? a0 : $urandom;
            end
            if (!req1 || last_g1 || ($urandom_range(0, 15) == 0)) begin
                req1 = ($urandom_range(0, 3) != 0);
                op1  = 2'($urandom_range(0, 3));
                a1   = $urandom;
                b1   = ($urandom_range(0, 7) == 0) ? a1 : $urandom;
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
